ks10_io_responder: RTL

Generic KS10 backplane-bus IO target: the responder end of the CPU's request/ack bus protocol. It decodes CPU IO requests for its controller number and register window, inserts a programmable number of wait states, then acknowledges and returns read data. It also holds an 8-word register bank, raises a priority interrupt, and answers the interrupt who-are-you (WRU) and vector cycles. It sits on the backplane beside memory and the UBAs, driving a wired-OR data bus.

---
 rtl/ks10_iodev_pkg.sv | 30 +++
 rtl/iodev_regbank.sv | 62 ++++++
 rtl/ks10_io_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ks10_iodev_pkg.sv
// Shared constants and types for the KS10 backplane IO responder.
// KS10 numbers word bits 0 (MSB) .. 35 (LSB); every index below is the Verilog index 35 - ks10_bit.
package ks10_iodev_pkg;

  localparam int F_READ   = 32;
  localparam int F_WRTEST = 31;
  localparam int F_WRITE  = 30;
  localparam int F_IO     = 25;
  localparam int F_WRU    = 24;
  localparam int F_VECT   = 23;
  localparam int F_IOBYTE = 22;

  localparam int CSR_IE     = 0;
  localparam int CSR_PRI_LO = 1;
  localparam int CSR_PRI_HI = 3;
  localparam int CSR_PEND   = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  typedef enum logic [1:0] {RD, WR, WRU, VECT} kind_t;

  function automatic logic [35:0] csr_word(input logic ie, input logic [2:0] pri, input logic pend);
    logic [35:0] w;
    w = '0;
    w[CSR_IE] = ie;
    w[CSR_PRI_HI:CSR_PRI_LO] = pri;
    w[CSR_PEND] = pend;
    return w;
  endfunction

endpackage

// File: rtl/iodev_regbank.sv
// 8 x 36 register bank: CSR (IE/PRI/PEND with W1C) at index 0, scratch at 1..7,
// plus the registered one-hot interrupt request.
module iodev_regbank
  import ks10_iodev_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [2:0]  idx_i,
  input  logic [35:0] wdata_i,
  input  logic        vect_clr_i,
  input  logic        event_i,
  output logic [35:0] rdata_o,
  output logic [7:1]  intr_o
);

  logic        ie_q, ie_d;
  logic [2:0]  pri_q, pri_d;
  logic        pend_q, pend_d;
  logic [7:1]  intr_q, intr_d;
  logic [35:0] scratch_q [7:1];
  logic        csr_we, pend_clr;

  always_comb begin
    csr_we   = we_i && (idx_i == 3'd0);
    ie_d     = csr_we ? wdata_i[CSR_IE] : ie_q;
    pri_d    = csr_we ? wdata_i[CSR_PRI_HI:CSR_PRI_LO] : pri_q;
    pend_clr = (csr_we && wdata_i[CSR_PEND]) || vect_clr_i;
    // A device event in the same cycle as a clear keeps the interrupt pending.
    pend_d   = event_i ? 1'b1 : (pend_clr ? 1'b0 : pend_q);
    // Interrupt tracks next-state so it drops in the same cycle PEND clears.
    intr_d   = '0;
    for (int i = 1; i <= 7; i++) begin
      intr_d[i] = ie_d && pend_d && (pri_d == 3'(i));
    end
  end

  always_comb begin
    rdata_o = '0;
    if (idx_i == 3'd0) rdata_o = csr_word(ie_q, pri_q, pend_q);
    else               rdata_o = scratch_q[idx_i];
  end

  assign intr_o = intr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q   <= 1'b0;
      pri_q  <= '0;
      pend_q <= 1'b0;
      intr_q <= '0;
      for (int i = 1; i <= 7; i++) scratch_q[i] <= '0;
    end else begin
      ie_q   <= ie_d;
      pri_q  <= pri_d;
      pend_q <= pend_d;
      intr_q <= intr_d;
      if (we_i && (idx_i != 3'd0)) scratch_q[idx_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/ks10_io_responder.sv
// KS10 backplane IO target: decodes register/WRU/VECT requests, inserts WAITS
// wait states, then pulses busACKO with registered read data.
module ks10_io_responder
  import ks10_iodev_pkg::*;
#(
  parameter logic [3:0]  DEVNUM   = 4'd3,
  parameter logic [17:0] BASEADDR = 18'o760000,
  parameter int          WAITS    = 2,
  parameter logic [17:0] VECTOR   = 18'o000250
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        busREQI,
  input  logic [35:0] busADDRI,
  input  logic [35:0] busDATAI,
  output logic        busACKO,
  output logic [35:0] busDATAO,
  output logic [7:1]  busINTRO,
  input  logic        devEVENT,
  output state_t      dbg_state_o
);

  localparam logic [3:0]  WAITS4   = 4'(WAITS);
  localparam logic [35:0] WRU_WORD = 36'h1 << (17 - int'(DEVNUM));

  // Handshake: busREQI is a one-cycle strobe sampled only in IDLE; busACKO is a
  // one-cycle pulse WAITS+1 cycles after accept, with busDATAO valid only then.
  state_t      state_q;
  kind_t       kind_q, hit_kind;
  logic [3:0]  cnt_q;
  logic [2:0]  idx_q;
  logic [35:0] wdata_q, data_q, resp, rdata;
  logic        ack_q;
  logic        io_req, ctl_match, win_match, lvl_hit, hit;
  logic        rb_we, rb_vect_clr;
  logic [2:0]  wru_lvl;

  wire unused_addr_bits = &{1'b0, busADDRI[35:33], busADDRI[F_READ], busADDRI[F_WRTEST],
                            busADDRI[29:26], busADDRI[F_IOBYTE]};

  always_comb begin
    io_req    = busREQI && busADDRI[F_IO];
    ctl_match = (busADDRI[21:18] == DEVNUM);
    win_match = (busADDRI[17:3] == BASEADDR[17:3]);
    wru_lvl   = busADDRI[20:18];
    lvl_hit   = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (wru_lvl == 3'(i)) lvl_hit = busINTRO[i];
    end
    hit      = 1'b0;
    hit_kind = RD;
    if (io_req) begin
      if (busADDRI[F_WRU]) begin
        hit      = lvl_hit;
        hit_kind = WRU;
      end else if (busADDRI[F_VECT]) begin
        hit      = ctl_match;
        hit_kind = VECT;
      end else if (ctl_match && win_match) begin
        hit      = 1'b1;
        hit_kind = busADDRI[F_WRITE] ? WR : RD;
      end
    end
  end

  always_comb begin
    resp = '0;
    case (kind_q)
      RD:      resp = rdata;
      WRU:     resp = WRU_WORD;
      VECT:    resp = {18'b0, VECTOR};
      default: resp = '0;
    endcase
  end

  assign rb_we       = (state_q == ACK) && (kind_q == WR);
  assign rb_vect_clr = (state_q == ACK) && (kind_q == VECT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      kind_q  <= RD;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      ack_q  <= 1'b0;
      data_q <= '0;
      case (state_q)
        IDLE: if (hit) begin
          kind_q  <= hit_kind;
          idx_q   <= busADDRI[2:0];
          wdata_q <= busDATAI;
          cnt_q   <= WAITS4;
          state_q <= (WAITS4 == 4'd0) ? ACK : WAIT;
        end
        WAIT: begin
          if (cnt_q <= 4'd1) state_q <= ACK;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ACK: begin
          ack_q   <= 1'b1;
          data_q  <= resp;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  iodev_regbank u_regbank (
    .clk        (clk),
    .rst_n      (rst),
    .we_i       (rb_we),
    .idx_i      (idx_q),
    .wdata_i    (wdata_q),
    .vect_clr_i (rb_vect_clr),
    .event_i    (devEVENT),
    .rdata_o    (rdata),
    .intr_o     (busINTRO)
  );

  assign busACKO     = ack_q;
  assign busDATAO    = data_q;
  assign dbg_state_o = state_q;

endmodule
